arbitro_ram: RTL and testbench
==============================

# arbitro_ram

Fixed-priority read arbiter and access sequencer for the board's asynchronous cellular RAM. It shares the single RAM port between the audio sample fetcher and the lower-priority video/note-chart reader. For each read it drives the RAM control strobes through a fixed wait-state count, captures the data word, and returns it to the requester with a one-cycle valid pulse. A starvation guard keeps video from being locked out by continuous audio traffic.

## Interface
- ADDR_W, 26, RAM word address width
- DATA_W, 16, RAM data width
- WAIT_CYC, 6, clk cycles the RAM access is held before sampling (≥1)
- MAX_STARVE, 4, consecutive audio grants tolerated while video waits (≥1)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- audio_req  in  1  audio read request; held with audio_addr until audio_gnt
- audio_addr  in  ADDR_W  audio read address
- audio_gnt  out  1  one-cycle pulse: audio request accepted, address latched
- audio_dato  out  DATA_W  audio read data; valid when audio_valido=1
- audio_valido  out  1  one-cycle pulse: audio_dato holds the completed read
- video_req, video_addr, video_gnt, video_dato, video_valido: same widths and semantics as the audio set
- ram_addr  out  ADDR_W  registered RAM address
- ram_ce_n  out  1  chip enable, active-low
- ram_oe_n  out  1  output enable, active-low
- ram_we_n  out  1  write enable, tied high (read-only)
- ram_adv_n  out  1  address valid, tied low (asynchronous mode)
- ram_dq  in  DATA_W  RAM data bus
- ocupado  out  1  high whenever the state is not IDLE

## Operation
- States: IDLE, ACCESO, CAPTURA.
- IDLE, any request present: pick a winner and pulse its gnt this cycle. At the clock edge, latch the winner's address into ram_addr, record the owner, load the wait counter with WAIT_CYC-1, and go to ACCESO.
- Winner selection: audio wins by default. Video wins if video_req=1 and audio_req=0, or if video_req=1 and the starvation counter equals MAX_STARVE.
- Starvation counter, 3 bits:
  - increments (saturating at MAX_STARVE) on each audio grant while video_req=1;
  - clears on a video grant, or in any cycle with video_req=0.
- ACCESO: ram_ce_n=0 and ram_oe_n=0. The counter decrements each cycle. When it reads 0, go to CAPTURA.
- CAPTURA: strobes stay low. At the edge, ram_dq is registered into the owner's dato register, and the owner's valido is set for the next cycle. Go to IDLE.
- IDLE following CAPTURA: strobes are high, valido pulses, and a new grant may issue in this same cycle.
- The non-owner's dato register holds its previous value.
- A request arriving while ocupado=1 waits; no gnt is issued until IDLE.
- The requester may drop req after gnt. Dropping req before gnt withdraws the request with no side effects.
- Reset values: state IDLE, ram_addr 0, ram_ce_n 1, ram_oe_n 1, ram_we_n 1, ram_adv_n 0, both gnt 0, both valido 0, both dato 0, starvation counter 0, ocupado 0.
- Reset during ACCESO or CAPTURA aborts the transaction: no valido is issued, and strobes are high the cycle after reset.

## Timing
- Grant at cycle T (IDLE).
- ACCESO: T+1 … T+WAIT_CYC.
- CAPTURA: T+WAIT_CYC+1.
- valido and data visible: T+WAIT_CYC+2.
- Strobes low for WAIT_CYC+1 cycles.
- gnt is combinational from IDLE and req. All other outputs are registered.
- Back-to-back throughput: one read per WAIT_CYC+2 cycles.
- With WAIT_CYC=6: gnt at T, valido at T+8, next gnt possible at T+8.
- If both reqs rise in the same IDLE cycle, exactly one gnt pulses.

## Test plan
- Reset check: assert reset 3 cycles mid-traffic → all outputs at reset values, ocupado=0, no spurious gnt/valido.
- Single audio read: RAM model returns 16'hA5C3 at addr 26'h0001234; audio_req pulsed at T → audio_gnt at T, ram_addr=26'h0001234 from T+1, ce/oe low T+1…T+7, audio_valido=1 with audio_dato=16'hA5C3 at T+8 only.
- Simultaneous requests: both raised at T → audio_gnt at T; video_gnt at T+8; video_valido at T+16; audio_dato unchanged by the video read.
- Starvation: both reqs held high continuously → grant order A,A,A,A,V,A,A,A,A,V…; video never waits more than 4 audio transactions.
- Reset during ACCESO: reset asserted at T+3 → strobes high at T+4, no valido; a fresh video_req then completes normally 8 cycles after its gnt.
- Back-to-back audio: audio_req held, address incrementing on each gnt → gnts at T, T+8, T+16, with each returned word matching its address.

Source files
------------

// File: rtl/arbitro_ram.sv
// Purpose: fixed-priority read arbiter and access sequencer for the shared async cellular RAM (audio over video, with starvation guard).
// Latency: gnt combinational in IDLE; read data + valido pulse WAIT_CYC+2 cycles after gnt; one read per WAIT_CYC+2 cycles.
// Backpressure: requesters hold req/addr until gnt; requests seen while ocupado=1 simply wait; valido has no ready (must be taken).
//
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   audio_req/addr -> audio_gnt   : audio request channel; audio_dato/audio_valido return the read word
//   video_req/addr -> video_gnt   : video/note-chart request channel; video_dato/video_valido return the read word
//   ram_addr, ram_*_n, ram_dq     : RAM address, active-low strobes and data bus
//   ocupado                       : high while a RAM access is in progress
module arbitro_ram #(
   parameter int ADDR_W     = 26,
   parameter int DATA_W     = 16,
   parameter int WAIT_CYC   = 6,
   parameter int MAX_STARVE = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              audio_req,
   input  logic [ADDR_W-1:0] audio_addr,
   output logic              audio_gnt,
   output logic [DATA_W-1:0] audio_dato,
   output logic              audio_valido,
   input  logic              video_req,
   input  logic [ADDR_W-1:0] video_addr,
   output logic              video_gnt,
   output logic [DATA_W-1:0] video_dato,
   output logic              video_valido,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_ce_n,
   output logic              ram_oe_n,
   output logic              ram_we_n,
   output logic              ram_adv_n,
   input  logic [DATA_W-1:0] ram_dq,
   output logic              ocupado
);

   localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESO  = 2'd1,
      CAPTURA = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2:0]          starve_q, starve_d;
   logic                owner_q, owner_d;      // 1 = video owns the current access
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                ce_n_q, ce_n_d;
   logic                oe_n_q, oe_n_d;
   logic [DATA_W-1:0]   audio_dat_q, audio_dat_d;
   logic [DATA_W-1:0]   video_dat_q, video_dat_d;
   logic                audio_vld_q, audio_vld_d;
   logic                video_vld_q, video_vld_d;

   logic                video_wins;
   logic                a_gnt, v_gnt;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      starve_d    = starve_q;
      owner_d     = owner_q;
      addr_d      = addr_q;
      ce_n_d      = ce_n_q;
      oe_n_d      = oe_n_q;
      audio_dat_d = audio_dat_q;
      video_dat_d = video_dat_q;
      audio_vld_d = 1'b0;
      video_vld_d = 1'b0;
      a_gnt       = 1'b0;
      v_gnt       = 1'b0;

      // Video takes the port when audio is absent, or when audio has had
      // MAX_STARVE consecutive grants while video was waiting.
      video_wins = video_req && (!audio_req || (starve_q == 3'(MAX_STARVE)));

      case (state_q)
         IDLE: begin
            if (audio_req || video_req) begin
               v_gnt   = video_wins;
               a_gnt   = !video_wins;
               owner_d = video_wins;
               addr_d  = video_wins ? video_addr : audio_addr;
               cnt_d   = CNT_W'(WAIT_CYC - 1);
               ce_n_d  = 1'b0;
               oe_n_d  = 1'b0;
               state_d = ACCESO;
            end
         end
         ACCESO: begin
            if (cnt_q == '0) begin
               state_d = CAPTURA;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         CAPTURA: begin
            // Strobes are still low during this cycle, so ram_dq is valid
            // at the closing edge; release them together with the capture.
            if (owner_q) begin
               video_dat_d = ram_dq;
               video_vld_d = 1'b1;
            end else begin
               audio_dat_d = ram_dq;
               audio_vld_d = 1'b1;
            end
            ce_n_d  = 1'b1;
            oe_n_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (!video_req || v_gnt) begin
         starve_d = 3'd0;
      end else if (a_gnt && (starve_q < 3'(MAX_STARVE))) begin
         starve_d = starve_q + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         starve_q    <= 3'd0;
         owner_q     <= 1'b0;
         addr_q      <= '0;
         ce_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         audio_dat_q <= '0;
         video_dat_q <= '0;
         audio_vld_q <= 1'b0;
         video_vld_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         starve_q    <= starve_d;
         owner_q     <= owner_d;
         addr_q      <= addr_d;
         ce_n_q      <= ce_n_d;
         oe_n_q      <= oe_n_d;
         audio_dat_q <= audio_dat_d;
         video_dat_q <= video_dat_d;
         audio_vld_q <= audio_vld_d;
         video_vld_q <= video_vld_d;
      end
   end

   // Grants are suppressed while reset is asserted so nothing is handed out
   // in a cycle whose state update is about to be discarded.
   assign audio_gnt    = a_gnt && !reset;
   assign video_gnt    = v_gnt && !reset;
   assign audio_dato   = audio_dat_q;
   assign audio_valido = audio_vld_q;
   assign video_dato   = video_dat_q;
   assign video_valido = video_vld_q;
   assign ram_addr     = addr_q;
   assign ram_ce_n     = ce_n_q;
   assign ram_oe_n     = oe_n_q;
   assign ram_we_n     = 1'b1;
   assign ram_adv_n    = 1'b0;
   assign ocupado      = (state_q != IDLE);

endmodule

// File: tb/tb_arbitro_ram.sv
// Purpose: randomized + directed bench for arbitro_ram with a cycle-level reference model and a valido scoreboard.
// Latency: model expects read data WAIT+2 cycles after each grant.
// Backpressure: requesters hold req until gnt, then drop or re-request with a new address.
module tb_arbitro_ram;

   localparam int ADDR_W = 26;
   localparam int DATA_W = 16;
   localparam int WAIT   = 6;
   localparam int MAXS   = 4;

   logic              clk;
   logic              reset;
   logic              audio_req, video_req;
   logic [ADDR_W-1:0] audio_addr, video_addr;
   logic              audio_gnt, video_gnt;
   logic [DATA_W-1:0] audio_dato, video_dato;
   logic              audio_valido, video_valido;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_ce_n, ram_oe_n, ram_we_n, ram_adv_n;
   logic [DATA_W-1:0] ram_dq;
   logic              ocupado;

   arbitro_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYC(WAIT), .MAX_STARVE(MAXS)) dut (
      .clk(clk), .reset(reset),
      .audio_req(audio_req), .audio_addr(audio_addr), .audio_gnt(audio_gnt),
      .audio_dato(audio_dato), .audio_valido(audio_valido),
      .video_req(video_req), .video_addr(video_addr), .video_gnt(video_gnt),
      .video_dato(video_dato), .video_valido(video_valido),
      .ram_addr(ram_addr), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n),
      .ram_we_n(ram_we_n), .ram_adv_n(ram_adv_n), .ram_dq(ram_dq), .ocupado(ocupado)
   );

   // RAM contents: fixed word at 0x1234, address hash elsewhere.
   function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
      if (a == 26'h0001234) return 16'hA5C3;
      return a[15:0] ^ {a[25:16], 6'h2b} ^ 16'h5a5a;
   endfunction

   assign ram_dq = (!ram_ce_n && !ram_oe_n) ? ram_word(ram_addr) : '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %0h want %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic flag(input string nm);
      n_cmp++;
      n_err++;
      $display("FAIL %s cycle %0d", nm, cyc);
   endtask

   typedef struct {
      bit                vid;
      logic [DATA_W-1:0] dat;
      int                due;
   } exp_t;
   exp_t exp_q[$];

   // ---------------- reference model ----------------
   int                m_busy_until = 0;
   int                m_last_g     = -1000;
   logic [ADDR_W-1:0] m_last_addr  = '0;
   int                m_starve     = 0;
   bit                m_prev_rst   = 1'b0;
   bit                m_ea, m_ev, m_low;

   always @(negedge clk) begin
      if (reset) begin
         chk("gnt_in_reset_a", audio_gnt, 0);
         chk("gnt_in_reset_v", video_gnt, 0);
         if (m_prev_rst) begin
            chk("rst_ce_n", ram_ce_n, 1);
            chk("rst_oe_n", ram_oe_n, 1);
            chk("rst_we_n", ram_we_n, 1);
            chk("rst_adv_n", ram_adv_n, 0);
            chk("rst_ocupado", ocupado, 0);
            chk("rst_ram_addr", ram_addr, 0);
         end
         // Aborted transactions never return data; a valido already on the
         // outputs this cycle came from before reset and is kept.
         for (int i = exp_q.size() - 1; i >= 0; i--)
            if (exp_q[i].due > cyc) exp_q.delete(i);
         m_busy_until = 0;
         m_last_g     = -1000;
         m_starve     = 0;
      end else begin
         m_ev = (cyc >= m_busy_until) && video_req && (!audio_req || m_starve == MAXS);
         m_ea = (cyc >= m_busy_until) && audio_req && !m_ev;
         chk("audio_gnt", audio_gnt, m_ea);
         chk("video_gnt", video_gnt, m_ev);
         m_low = (cyc > m_last_g) && (cyc <= m_last_g + WAIT + 1);
         chk("ram_ce_n", ram_ce_n, !m_low);
         chk("ram_oe_n", ram_oe_n, !m_low);
         chk("ram_we_n", ram_we_n, 1);
         chk("ram_adv_n", ram_adv_n, 0);
         chk("ocupado", ocupado, m_low);
         if (m_low) chk("ram_addr", ram_addr, m_last_addr);
         if (m_ea || m_ev) begin
            m_last_g     = cyc;
            m_last_addr  = m_ev ? video_addr : audio_addr;
            m_busy_until = cyc + WAIT + 2;
            exp_q.push_back('{vid: m_ev, dat: ram_word(m_last_addr), due: cyc + WAIT + 2});
         end
         if (!video_req || m_ev) m_starve = 0;
         else if (m_ea && m_starve < MAXS) m_starve++;
      end
      m_prev_rst = reset;
   end

   // ---------------- scoreboard monitor ----------------
   logic [DATA_W-1:0] x_adat = '0;
   logic [DATA_W-1:0] x_vdat = '0;
   bit                x_prev_rst = 1'b0;
   exp_t              x_e;

   always @(negedge clk) begin
      if (x_prev_rst) begin
         x_adat = '0;
         x_vdat = '0;
      end
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
         flag("missing_valido");
         void'(exp_q.pop_front());
      end
      if (audio_valido && video_valido) begin
         flag("both_valido");
      end else if (audio_valido || video_valido) begin
         if (exp_q.size() == 0) begin
            flag("spurious_valido");
         end else begin
            x_e = exp_q.pop_front();
            chk("valido_owner", video_valido, x_e.vid);
            chk("valido_cycle", cyc, x_e.due);
            if (x_e.vid) x_vdat = x_e.dat;
            else         x_adat = x_e.dat;
         end
      end
      chk("audio_dato", audio_dato, x_adat);
      chk("video_dato", video_dato, x_vdat);
      x_prev_rst = reset;
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(input bit vid);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(vid ? video_gnt : audio_gnt) && k < 40);
      if (!(vid ? video_gnt : audio_gnt)) flag(vid ? "video_gnt_timeout" : "audio_gnt_timeout");
   endtask

   bit ga, gv;

   initial begin
      reset = 1'b1; audio_req = 1'b0; video_req = 1'b0;
      audio_addr = '0; video_addr = '0;
      repeat (3) step();
      reset = 1'b0;
      repeat (2) step();

      // single audio read of the fixed word
      audio_req = 1'b1; audio_addr = 26'h0001234;
      wait_gnt(1'b0);
      step(); audio_req = 1'b0;
      repeat (10) step();

      // simultaneous requests
      audio_req = 1'b1; audio_addr = 26'h0000100;
      video_req = 1'b1; video_addr = 26'h0000200;
      wait_gnt(1'b0);
      step(); audio_req = 1'b0;
      wait_gnt(1'b1);
      step(); video_req = 1'b0;
      repeat (10) step();

      // starvation: both held, addresses advance per grant
      audio_req = 1'b1; video_req = 1'b1;
      audio_addr = 26'h0010000; video_addr = 26'h0020000;
      repeat (100) begin
         @(negedge clk); ga = audio_gnt; gv = video_gnt;
         step();
         if (ga) audio_addr = audio_addr + 1'b1;
         if (gv) video_addr = video_addr + 1'b1;
      end
      video_req = 1'b0;

      // back-to-back audio
      repeat (30) begin
         @(negedge clk); ga = audio_gnt;
         step();
         if (ga) audio_addr = audio_addr + 1'b1;
      end
      audio_req = 1'b0;
      repeat (10) step();

      // reset during ACCESO, then a fresh video read
      audio_req = 1'b1; audio_addr = 26'h0003333;
      wait_gnt(1'b0);
      step(); audio_req = 1'b0;
      step();
      step(); reset = 1'b1;
      step(); reset = 1'b0;
      repeat (3) step();
      video_req = 1'b1; video_addr = 26'h0004444;
      wait_gnt(1'b1);
      step(); video_req = 1'b0;
      repeat (12) step();

      // random traffic with occasional 3-cycle resets
      repeat (1500) begin
         @(negedge clk); ga = audio_gnt; gv = video_gnt;
         step();
         if (ga || !audio_req) begin
            audio_req  = ($urandom % 3) != 0;
            audio_addr = ADDR_W'($urandom);
         end else if ($urandom % 16 == 0) begin
            audio_req = 1'b0;
         end
         if (gv || !video_req) begin
            video_req  = ($urandom % 2) != 0;
            video_addr = ADDR_W'($urandom);
         end else if ($urandom % 16 == 0) begin
            video_req = 1'b0;
         end
         if ($urandom % 150 == 0) begin
            reset = 1'b1;
            repeat (3) step();
            reset = 1'b0;
         end
      end

      audio_req = 1'b0; video_req = 1'b0;
      repeat (20) step();
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
